// File: rtl/uart_pkg.sv
// Shared definitions for the 8-bit UART transmitter.
//   state_t    : FSM state encoding (PARITY is used only when UART_TX_PARITY_EN is defined)
//   DATA_BITS  : payload bits per frame
//   IDLE_LEVEL : mark level of the serial line
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_8bits_if.sv
// Word handshake between the upstream counter and the UART transmitter.
//   data_in    : word offered by upstream
//   data_valid : upstream has a word on data_in
//   data_ready : transmitter can accept a word this cycle
// Handshake: a word transfers on every rising clk edge where data_valid and
// data_ready are both 1. Upstream holds data_in/data_valid stable until that
// edge; data_valid while data_ready=0 is ignored and nothing is dropped.
interface uart_tx_8bits_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_in, output data_valid, input  data_ready);
  modport slave  (input  data_in, input  data_valid, output data_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Baud-rate divider for the UART transmitter.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : holds the counter at 0 (used while the transmitter is idle)
//   tick  : high for the one cycle in which the counter equals CLKS_PER_BIT-1
// The counter wraps to 0 on the tick cycle, so each serial bit lasts exactly
// CLKS_PER_BIT cycles.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_8bits.sv
// 8-bit UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is
// defined (frame grows from 10 to 11 bit times).
//   clk       : system clock, all state changes on the rising edge
//   rst       : synchronous active-high reset; abandons any frame in flight
//   bus       : word handshake (slave side): data_in, data_valid, data_ready
//   tx        : registered serial output, idle level 1
//   busy      : frame in progress (inverse of data_ready outside reset)
//   state_dbg : current FSM state, for observation only
module uart_tx_8bits
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_8bits_if.slave   bus,
  output logic             tx,
  output logic             busy,
  output state_t           state_dbg
);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  // Counter is held at 0 throughout IDLE, so the accept edge leaves it at 0
  // and the start bit gets a full CLKS_PER_BIT cycles.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // Ready is gated by rst so no word can be accepted on a reset edge.
  assign bus.data_ready = (state == IDLE) && !rst;
  assign busy           = (state != IDLE);
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= IDLE_LEVEL;
      shift   <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (bus.data_valid) begin
            shift   <= bus.data_in;
            bit_idx <= '0;
            state   <= START;
            tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= ^bus.data_in;
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= IDLE_LEVEL;
`endif
            end else begin
              // tx is loaded from shift[1] because shift[0] is the bit
              // currently on the line.
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            tx    <= IDLE_LEVEL;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8bits.sv
// Testbench for uart_tx_8bits (CLKS_PER_BIT=16). Honours UART_TX_PARITY_EN.
module tb_uart_tx_8bits;
  import uart_pkg::*;

  localparam int N = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   tx;
  logic   busy;
  state_t state_dbg;
  int     ec = 0;   // number of rising edges so far

  uart_tx_8bits_if bus();

  uart_tx_8bits #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tx        (tx),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         acc_q[$];   // edge index k at which each word is accepted
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Offers d at a falling edge and waits for ready; records the accept edge.
  task automatic send(input logic [7:0] d, input bit release_after);
    int budget;
    budget = 4 * FRAME_BITS * N;
    @(negedge clk);
    bus.data_in    = d;
    bus.data_valid = 1'b1;
    while (!bus.data_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.data_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      exp_q.push_back(d);
      acc_q.push_back(ec + 1);
    end
    @(posedge clk);
    #1;
    if (release_after) bus.data_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  task automatic expect_frames(input int nf);
    int         budget, k, hits, ready_low, busy_high;
    logic [7:0] d;
    logic       eb[0:10];
    for (int f = 0; f < nf; f++) begin
      budget = 4 * FRAME_BITS * N;
      @(negedge clk);
      while (tx !== 1'b0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (tx !== 1'b0) begin
        check("start_timeout", 0, 1);
        return;
      end
      if (exp_q.size() == 0) begin
        check("spurious_frame", 1, 0);
        return;
      end
      d = exp_q.pop_front();
      k = acc_q.pop_front();
      check("start_cycle", ec + 1, k + 1);
      eb[0] = 1'b0;
      for (int i = 0; i < 8; i++) eb[i+1] = d[i];
      eb[9]  = ^d;
      eb[10] = 1'b1;
      eb[FRAME_BITS-1] = 1'b1;
      ready_low = 0;
      busy_high = 0;
      for (int j = 0; j < FRAME_BITS; j++) begin
        hits = 0;
        for (int c = 0; c < N; c++) begin
          if (!(j == 0 && c == 0)) @(negedge clk);
          if (tx === eb[j]) hits++;
          if (bus.data_ready === 1'b0) ready_low++;
          if (busy === 1'b1) busy_high++;
        end
        check($sformatf("d%02h_bit%0d", d, j), hits, N);
      end
      check($sformatf("d%02h_ready_low", d), ready_low, FRAME_BITS * N);
      check($sformatf("d%02h_busy_high", d), busy_high, FRAME_BITS * N);
      @(negedge clk);
      check("ready_after_frame", int'(bus.data_ready), 1);
      check("busy_after_frame", int'(busy), 0);
      check("tx_after_frame", int'(tx), 1);
    end
  endtask

  // Line must stay at mark level with no frame started.
  task automatic expect_idle(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (tx === 1'b1 && state_dbg == IDLE) hits++;
    end
    check(tag, hits, cycles);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;

    // Reset held 3+ cycles; valid offered during the last reset edge.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(bus.data_ready), 0);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(state_dbg), int'(IDLE));
    bus.data_in    = 8'hC3;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    check("rel_ready", int'(bus.data_ready), 1);
    check("rel_busy_no_accept", int'(busy), 0);
    expect_idle("rel_idle", 4);

    // Single frame.
    fork
      send(8'hA5, 1'b1);
      expect_frames(1);
    join

    // Back-to-back with valid held high.
    fork
      begin
        send(8'h00, 1'b0);
        send(8'hFF, 1'b1);
      end
      expect_frames(2);
    join

    // Input activity during a frame must not disturb it.
    fork
      begin
        send(8'h3C, 1'b1);
        repeat (FRAME_BITS * N - 20) begin
          @(negedge clk);
          bus.data_in    = 8'($urandom_range(0, 255));
          bus.data_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.data_valid = 1'b0;
      end
      expect_frames(1);
    join
    expect_idle("no_extra_frame", 3 * N);

    // Random words, streamed.
    fork
      for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), i == 3);
      expect_frames(4);
    join

    // Parity-relevant word (parity bit 1 when enabled).
    fork
      send(8'h07, 1'b1);
      expect_frames(1);
    join

    // Reset mid-frame: bit 2 of 0x5A is 0, so tx is low when rst hits.
    send(8'h5A, 1'b1);
    k = acc_q[acc_q.size()-1];
    while (ec + 1 < k + 50) @(negedge clk);
    check("pre_rst_tx_low", int'(tx), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("mid_rst_tx", int'(tx), 1);
    check("mid_rst_state", int'(state_dbg), int'(IDLE));
    check("mid_rst_ready", int'(bus.data_ready), 1);
    expect_idle("mid_rst_idle", 2 * N);

    fork
      send(8'h55, 1'b1);
      expect_frames(1);
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
